// File: rtl/shift_rx_pkg.sv
// Shared types and constants for the shift_rx serial receiver.
// SHIFT_RX_PARITY_EN adds the PARITY state (even-parity bit after each word).
package shift_rx_pkg;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

`ifdef SHIFT_RX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

endpackage

// File: rtl/shift_rx_core.sv
// Bidirectional shift register with bit counter; word_c is the register's
// value after the current cycle's shift, so a completing word can be taken directly.
module shift_rx_core
    import shift_rx_pkg::*;
#(
    parameter int unsigned N_WIDTH = 4,
    localparam int unsigned CNT_W  = $clog2(N_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               start,
    input  logic               step,
    input  logic               dir,
    input  logic               bit_in,
    output logic [N_WIDTH-1:0] word_c,
    output logic [CNT_W-1:0]   count
);

    logic [N_WIDTH-1:0] sreg;
    logic [N_WIDTH-1:0] first_c;
    logic [N_WIDTH-1:0] next_c;
    logic               dir_q;

    // A restart clears any partial word so only the new first bit remains.
    always_comb begin
        first_c = (dir == DIR_MSB_FIRST) ? {(N_WIDTH-1)'(0), bit_in}
                                         : {bit_in, (N_WIDTH-1)'(0)};
        next_c  = (dir_q == DIR_MSB_FIRST) ? {sreg[N_WIDTH-2:0], bit_in}
                                           : {bit_in, sreg[N_WIDTH-1:1]};
        word_c  = step ? next_c : sreg;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sreg  <= '0;
            count <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else if (start) begin
            sreg  <= first_c;
            count <= CNT_W'(1);
            dir_q <= dir;
        end else if (step) begin
            sreg  <= next_c;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_rx.sv
// Framed serial-to-parallel receiver with a one-word output buffer and flags.
// Optional even-parity check is enabled by defining SHIFT_RX_PARITY_EN.
module shift_rx
    import shift_rx_pkg::*;
#(
    parameter int unsigned N_WIDTH = 4
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               ser_in,
    input  logic               ser_en,
    input  logic               sof,
    input  logic               dir,
    output logic [N_WIDTH-1:0] data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               busy,
    output logic               overrun,
    output logic               parity_err
);

    localparam int unsigned CNT_W = $clog2(N_WIDTH + 1);

    state_t             state_q;
    state_t             state_d;
    logic               start_c;
    logic               step_c;
    logic               complete_c;
    logic               last_bit_c;
    logic [N_WIDTH-1:0] word_c;
    logic [CNT_W-1:0]   count;
`ifdef SHIFT_RX_PARITY_EN
    logic               perr_c;
`endif

    shift_rx_core #(.N_WIDTH(N_WIDTH)) u_core (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (start_c),
        .step    (step_c),
        .dir     (dir),
        .bit_in  (ser_in),
        .word_c  (word_c),
        .count   (count)
    );

    assign last_bit_c = (count == CNT_W'(N_WIDTH - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and datapath strobes; sof always restarts a frame.
    always_comb begin
        state_d    = state_q;
        start_c    = 1'b0;
        step_c     = 1'b0;
        complete_c = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
        perr_c     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ser_en && sof) begin
                    start_c = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en && sof) begin
                    start_c = 1'b1;
                end else if (ser_en) begin
                    step_c = 1'b1;
                    if (last_bit_c) begin
`ifdef SHIFT_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d    = IDLE;
                        complete_c = 1'b1;
`endif
                    end
                end
            end
`ifdef SHIFT_RX_PARITY_EN
            PARITY: begin
                if (ser_en && sof) begin
                    start_c = 1'b1;
                    state_d = SHIFT;
                end else if (ser_en) begin
                    state_d = IDLE;
                    if ((^word_c) == ser_in) complete_c = 1'b1;
                    else                     perr_c     = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output buffer: a completion is dropped only if the old word is still held.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (complete_c) begin
                if (!data_valid || data_ready) begin
                    data_out   <= word_c;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) parity_err <= 1'b0;
        else          parity_err <= perr_c;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
